writeback_arbiter: RTL

//  Merges ALU results and load-unit results onto the single write port
//  (ZielRegister/ZielDaten/Schreibsignal) of the 64x32 register file.
//  ALU has fixed priority; load results are buffered in a FIFO until a free slot.
//  A pending-write query lets the decoder stall on RAW hazards against buffered loads.

---
 rtl/writeback_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Merges ALU results and load-unit results onto the single write port
// (ZielRegister / ZielDaten / Schreibsignal) of the register file. The ALU
// always wins the slot. Load results wait in a small FIFO until a cycle in
// which the ALU does not write. The decoder can ask whether a register still
// has a write in flight (query_reg / query_pending) so that it can stall on
// RAW hazards against buffered loads.
//
// Ports
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   alu_valid/ziel/daten    ALU result; there is no back-pressure
//   mem_valid/ready         load-result handshake into the FIFO
//   mem_ziel/daten          load destination register and data
//   query_reg               register index the decoder wants to read
//   query_pending           a not-yet-committed write targets query_reg
//   fifo_count              number of buffered load results (0..FIFO_DEPTH)
//   ZielRegister/ZielDaten  registered write address/data to the register file
//   Schreibsignal           registered write enable to the register file
//
// Handshake: a load transfer happens on a rising edge where
// mem_valid && mem_ready are both high. mem_ready depends only on Reset and
// the current fill level, never on mem_valid, so the producer may hold
// mem_valid with stable data until it sees mem_ready. A transfer with
// mem_ziel == 0 completes but nothing is stored (register 0 is never written).
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          alu_valid,
    input  logic [ADDR_WIDTH-1:0]         alu_ziel,
    input  logic [DATA_WIDTH-1:0]         alu_daten,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_WIDTH-1:0]         mem_ziel,
    input  logic [DATA_WIDTH-1:0]         mem_daten,
    input  logic [ADDR_WIDTH-1:0]         query_reg,
    output logic                          query_pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [ADDR_WIDTH-1:0]         ZielRegister,
    output logic [DATA_WIDTH-1:0]         ZielDaten,
    output logic                          Schreibsignal
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Load-result buffer. Contents are not reset: validity is defined purely
    // by head/count, so stale entries are harmless.
    logic [ADDR_WIDTH-1:0] r_fifo_ziel  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_daten [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  r_schreib;
    logic [ADDR_WIDTH-1:0] r_ziel_reg;
    logic [DATA_WIDTH-1:0] r_ziel_daten;

    logic w_mem_ready;
    logic w_push;
    logic w_alu_win;
    logic w_pop;
    logic w_fifo_hit;

    // Ready deliberately ignores a pop in the same cycle: a full FIFO refuses
    // even while draining, which keeps ready free of the arbitration path.
    assign w_mem_ready = !Reset && (r_count < DEPTH_C);
    assign w_push      = mem_valid && w_mem_ready && (mem_ziel != '0);

    // An ALU result aimed at register 0 is a no-op and must not steal the slot.
    assign w_alu_win   = alu_valid && (alu_ziel != '0);
    assign w_pop       = !Reset && !w_alu_win && (r_count != '0);

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fifo_ziel[r_tail]  <= mem_ziel;
            r_fifo_daten[r_tail] <= mem_daten;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------- write port
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_schreib    <= 1'b0;
            r_ziel_reg   <= '0;
            r_ziel_daten <= '0;
        end else if (w_alu_win) begin
            r_schreib    <= 1'b1;
            r_ziel_reg   <= alu_ziel;
            r_ziel_daten <= alu_daten;
        end else if (w_pop) begin
            r_schreib    <= 1'b1;
            r_ziel_reg   <= r_fifo_ziel[r_head];
            r_ziel_daten <= r_fifo_daten[r_head];
        end else begin
            // Address/data hold their last value; only the enable drops.
            r_schreib    <= 1'b0;
        end
    end

    // ------------------------------------------------------ hazard query
    // Entry i is live when its distance from head (mod depth) is below count.
    always_comb begin
        w_fifo_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (({1'b0, PTR_W'(i) - r_head} < r_count) &&
                (r_fifo_ziel[i] == query_reg)) begin
                w_fifo_hit = 1'b1;
            end
        end
    end

    // Only state is consulted: this cycle's alu_* / mem_* inputs are excluded.
    assign query_pending = (query_reg != '0) &&
                           (w_fifo_hit || (r_schreib && (r_ziel_reg == query_reg)));

    assign mem_ready     = w_mem_ready;
    assign fifo_count    = r_count;
    assign Schreibsignal = r_schreib;
    assign ZielRegister  = r_ziel_reg;
    assign ZielDaten     = r_ziel_daten;

endmodule
